// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data-memory responder with byte-lane writes
// and a fixed number of wait states between accept and ack.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wr,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0] WS_M1 =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wr;
    logic [31:0]      r_mem [DEPTH];

    logic              w_resp;
    logic              w_oor;
    logic [MEM_AW-1:0] w_midx;
    logic [31:0]       w_old;
    logic [31:0]       w_merged;

    assign w_resp = (r_state == S_RESP);
    assign w_oor  = ({1'b0, r_idx} >= DEPTH_L);
    assign w_midx = r_idx[MEM_AW-1:0];

    // Old word (zero when out of range) merged with the enabled write lanes
    always_comb begin
        w_old    = w_oor ? 32'd0 : r_mem[w_midx];
        w_merged = w_old;
        for (int n = 0; n < 4; n++) begin
            if (r_wr[n]) begin
                w_merged[8*n +: 8] = r_wdata[8*n +: 8];
            end
        end
    end

    assign ack   = w_resp;
    assign err   = w_resp && w_oor;
    assign rdata = (w_resp && !w_oor) ? w_merged : 32'd0;
    assign busy  = (r_state != S_IDLE);

    // Request FSM: latch on accept, count wait states, one-cycle response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_wr    <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_idx   <= addr[ADDR_W-1:2];
                        r_wdata <= wdata;
                        r_wr    <= wr;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WS_M1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage: cleared on reset, merged word committed at the end of RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_resp && !w_oor && (r_wr != 4'd0)) begin
            r_mem[w_midx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder, one instance with
// default parameters and one with WAIT_STATES=0, DEPTH=16.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req = 1'b0;
    logic [7:0]  a_addr = 8'h00;
    logic [31:0] a_wdata = 32'h0;
    logic [3:0]  a_wr = 4'h0;
    logic        a_ack;
    logic [31:0] a_rdata;
    logic        a_busy;
    logic        a_err;

    logic        b_req = 1'b0;
    logic [7:0]  b_addr = 8'h00;
    logic [31:0] b_wdata = 32'h0;
    logic [3:0]  b_wr = 4'h0;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        b_busy;
    logic        b_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder u_a (
        .clk   (clk),
        .rst   (rst),
        .req   (a_req),
        .addr  (a_addr),
        .wdata (a_wdata),
        .wr    (a_wr),
        .ack   (a_ack),
        .rdata (a_rdata),
        .busy  (a_busy),
        .err   (a_err)
    );

    dmem_responder #(
        .ADDR_W      (8),
        .DEPTH       (16),
        .WAIT_STATES (0)
    ) u_b (
        .clk   (clk),
        .rst   (rst),
        .req   (b_req),
        .addr  (b_addr),
        .wdata (b_wdata),
        .wr    (b_wr),
        .ack   (b_ack),
        .rdata (b_rdata),
        .busy  (b_busy),
        .err   (b_err)
    );

    // Issue one transaction (called on a negedge) and wait, bounded, for ack
    task automatic xact(input bit sel, input logic [7:0] ad,
                        input logic [31:0] wd, input logic [3:0] we,
                        output logic [31:0] rd, output logic er);
        int n;
        logic got;
        if (sel) begin
            b_req = 1'b1; b_addr = ad; b_wdata = wd; b_wr = we;
        end else begin
            a_req = 1'b1; a_addr = ad; a_wdata = wd; a_wr = we;
        end
        n = 0;
        got = 1'b0;
        rd = 32'h0;
        er = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = sel ? b_ack : a_ack;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ack_timeout sel=%0d addr=%h: no ack within %0d cycles",
                     sel, ad, n);
        end else begin
            rd = sel ? b_rdata : a_rdata;
            er = sel ? b_err : a_err;
        end
        if (sel) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0) begin
            failures++; $display("FAIL rst_a_ack got=%b exp=0", a_ack);
        end
        checks++;
        if (a_busy !== 1'b0) begin
            failures++; $display("FAIL rst_a_busy got=%b exp=0", a_busy);
        end
        checks++;
        if (a_err !== 1'b0) begin
            failures++; $display("FAIL rst_a_err got=%b exp=0", a_err);
        end
        checks++;
        if (a_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_a_rdata got=%h exp=0", a_rdata);
        end
        checks++;
        if (b_ack !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_b ack=%b busy=%b exp=0/0", b_ack, b_busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_latency();
        a_req = 1'b1; a_addr = 8'h10; a_wr = 4'h0; a_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_ack !== 1'b0) begin
            failures++;
            $display("FAIL lat_wait busy=%b ack=%b exp=1/0", a_busy, a_ack);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b1 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL lat_ack ack=%b busy=%b exp=1/1", a_ack, a_busy);
        end
        checks++;
        if (a_rdata !== 32'h0 || a_err !== 1'b0) begin
            failures++;
            $display("FAIL lat_data rdata=%h err=%b exp=0/0", a_rdata, a_err);
        end
        a_req = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_ack !== 1'b0) begin
            failures++;
            $display("FAIL lat_idle busy=%b ack=%b exp=0/0", a_busy, a_ack);
        end
    endtask

    task automatic test_write_merge();
        logic [31:0] rd;
        logic er;
        xact(1'b0, 8'h08, 32'hDEADBEEF, 4'b1111, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_full got=%h exp=deadbeef", rd);
        end
        @(negedge clk);
        xact(1'b0, 8'h0B, 32'h000000AA, 4'b0001, rd, er);
        checks++;
        if (rd !== 32'hDEADBEAA) begin
            failures++; $display("FAIL wr_lane0 got=%h exp=deadbeaa", rd);
        end
        @(negedge clk);
        xact(1'b0, 8'h08, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
            failures++;
            $display("FAIL rd_merge got=%h err=%b exp=deadbeaa/0", rd, er);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        b_req = 1'b1; b_addr = 8'h04; b_wdata = 32'h12345678; b_wr = 4'b1100;
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1 || b_rdata !== 32'h12340000) begin
            failures++;
            $display("FAIL ws0_ack ack=%b rdata=%h exp=1/12340000",
                     b_ack, b_rdata);
        end
        b_addr = 8'h04; b_wdata = 32'h0; b_wr = 4'b0000;
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL ws0_gap ack=%b busy=%b exp=0/0", b_ack, b_busy);
        end
        @(negedge clk);
        checks++;
        if (b_ack !== 1'b1 || b_rdata !== 32'h12340000) begin
            failures++;
            $display("FAIL ws0_b2b ack=%b rdata=%h exp=1/12340000",
                     b_ack, b_rdata);
        end
        b_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_stable();
        logic [31:0] rd;
        logic er;
        int n;
        a_req = 1'b1; a_addr = 8'h14; a_wdata = 32'h11223344; a_wr = 4'b1111;
        @(negedge clk);
        a_addr = 8'h18; a_wdata = 32'h55667788; a_wr = 4'b0001;
        n = 0;
        while (a_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (a_rdata !== 32'h11223344) begin
            failures++;
            $display("FAIL hold_resp got=%h exp=11223344", a_rdata);
        end
        a_req = 1'b0;
        @(negedge clk);
        xact(1'b0, 8'h18, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL hold_other got=%h exp=0", rd);
        end
        @(negedge clk);
        xact(1'b0, 8'h14, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'h11223344) begin
            failures++; $display("FAIL hold_mem got=%h exp=11223344", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        a_req = 1'b1; a_addr = 8'h20; a_wdata = 32'hFFFFFFFF; a_wr = 4'b1111;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_ack !== 1'b0) begin
            failures++;
            $display("FAIL rmid_wait busy=%b ack=%b exp=1/0", a_busy, a_ack);
        end
        rst = 1'b1;
        a_req = 1'b0;
        #1;
        checks++;
        if (a_busy !== 1'b0) begin
            failures++; $display("FAIL rmid_async busy=%b exp=0", a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0) begin
            failures++; $display("FAIL rmid_noack ack=%b exp=0", a_ack);
        end
        rst = 1'b0;
        @(negedge clk);
        xact(1'b0, 8'h20, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL rmid_nowrite got=%h exp=0", rd);
        end
        @(negedge clk);
        xact(1'b0, 8'h08, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL rmid_clear got=%h exp=0", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic er;
        xact(1'b1, 8'h3C, 32'hCAFEF00D, 4'b1111, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            failures++;
            $display("FAIL oor_last got=%h err=%b exp=cafef00d/0", rd, er);
        end
        @(negedge clk);
        xact(1'b1, 8'h40, 32'hFFFFFFFF, 4'b1111, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL oor_resp err=%b rdata=%h exp=1/0", er, rd);
        end
        @(negedge clk);
        xact(1'b1, 8'h3C, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            failures++; $display("FAIL oor_keep15 got=%h exp=cafef00d", rd);
        end
        @(negedge clk);
        xact(1'b1, 8'h01, 32'h0, 4'b0000, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            failures++;
            $display("FAIL oor_keep0 got=%h err=%b exp=0/0", rd, er);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_merge();
        test_back_to_back();
        test_hold_stable();
        test_reset_mid();
        test_out_of_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
